// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve hold, play, point pause, match over.
// Tracks both scores, the serve direction and the winner; all outputs are registered.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_hold,
    output logic       play_en,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam logic [3:0] WIN_Q      = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_e     state_q;
    logic       ball_hold_q;
    logic       play_en_q;
    logic       serve_dir_q;
    logic [3:0] score_left_q;
    logic [3:0] score_right_q;
    logic [1:0] winner_q;
    logic [7:0] frame_cnt_q;
    logic       start_prev_q;
    logic       start_armed_q;

    logic [3:0] score_left_d;
    logic [3:0] score_right_d;
    logic       start_rise;

    // Saturating increments: a score parked at 15 stays there.
    assign score_left_d  = (score_left_q  == 4'hF) ? score_left_q  : score_left_q  + 4'd1;
    assign score_right_d = (score_right_q == 4'hF) ? score_right_q : score_right_q + 4'd1;

    // A start level held high across reset release must first drop before it can count.
    assign start_rise = start & ~start_prev_q & start_armed_q;

    // NOTE: async reset puts every register in its idle value immediately; all state updates use <=.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ball_hold_q   <= 1'b1;
            play_en_q     <= 1'b0;
            serve_dir_q   <= 1'b1;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            winner_q      <= 2'b00;
            frame_cnt_q   <= 8'd0;
            start_prev_q  <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            start_prev_q <= start;
            if (!start) begin
                start_armed_q <= 1'b1;
            end

            case (state_q)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state_q       <= SERVE;
                        score_left_q  <= 4'd0;
                        score_right_q <= 4'd0;
                        winner_q      <= 2'b00;
                        frame_cnt_q   <= 8'd0;
                    end
                end

                SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == SERVE_LAST) begin
                            state_q     <= PLAY;
                            frame_cnt_q <= 8'd0;
                            ball_hold_q <= 1'b0;
                            play_en_q   <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                PLAY: begin
                    if (miss_left || miss_right) begin
                        state_q     <= POINT;
                        frame_cnt_q <= 8'd0;
                        ball_hold_q <= 1'b1;
                        play_en_q   <= 1'b0;
                        // Both misses at once replays the point from the other side.
                        if (miss_left && miss_right) begin
                            serve_dir_q <= ~serve_dir_q;
                        end else if (miss_left) begin
                            score_right_q <= score_right_d;
                            serve_dir_q   <= 1'b0;
                        end else begin
                            score_left_q <= score_left_d;
                            serve_dir_q  <= 1'b1;
                        end
                    end
                end

                POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == POINT_LAST) begin
                            frame_cnt_q <= 8'd0;
                            if (score_left_q >= WIN_Q || score_right_q >= WIN_Q) begin
                                state_q  <= OVER;
                                winner_q <= (score_left_q >= WIN_Q) ? 2'b01 : 2'b10;
                            end else begin
                                state_q <= SERVE;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    frame_cnt_q <= 8'd0;
                    ball_hold_q <= 1'b1;
                    play_en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ball_hold   = ball_hold_q;
    assign play_en     = play_en_q;
    assign serve_dir   = serve_dir_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve timing, scoring, replays, match end and reset.
module tb_pong_game_ctrl;

    logic       pclk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       ball_hold;
    logic       play_en;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pong_game_ctrl #(
        .WIN_SCORE   (7),
        .SERVE_FRAMES(60),
        .POINT_FRAMES(30)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .ball_hold  (ball_hold),
        .play_en    (play_en),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .winner     (winner),
        .state      (state)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge, so outputs are sampled well clear of it.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        cyc();
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        #2;
        check("rst_state", 8'(state), 8'd0);
        check("rst_hold", 8'(ball_hold), 8'd1);
        check("rst_play", 8'(play_en), 8'd0);
        check("rst_dir", 8'(serve_dir), 8'd1);
        check("rst_sl", 8'(score_left), 8'd0);
        check("rst_sr", 8'(score_right), 8'd0);
        check("rst_win", 8'(winner), 8'd0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Start edge, then start held high through the whole serve with stray misses.
        start = 1'b1;
        cyc();
        check("start_serve", 8'(state), 8'd1);
        check("serve_hold", 8'(ball_hold), 8'd1);
        miss(1'b1, 1'b1);
        ticks(59);
        check("serve_59_state", 8'(state), 8'd1);
        check("serve_59_play", 8'(play_en), 8'd0);
        check("serve_miss_sl", 8'(score_left), 8'd0);
        check("serve_miss_sr", 8'(score_right), 8'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("serve_60_state", 8'(state), 8'd2);
        check("serve_60_play", 8'(play_en), 8'd1);
        check("serve_60_hold", 8'(ball_hold), 8'd0);
        cyc();
        start = 1'b0;

        // Ticks in PLAY do nothing; a left miss scores for the right player.
        ticks(3);
        check("play_tick_state", 8'(state), 8'd2);
        miss(1'b1, 1'b0);
        check("ml_sr", 8'(score_right), 8'd1);
        check("ml_sl", 8'(score_left), 8'd0);
        check("ml_dir", 8'(serve_dir), 8'd0);
        check("ml_state", 8'(state), 8'd3);
        check("ml_play", 8'(play_en), 8'd0);
        miss(1'b0, 1'b1);
        ticks(29);
        check("point_29_state", 8'(state), 8'd3);
        check("point_miss_sl", 8'(score_left), 8'd0);
        ticks(1);
        check("point_30_state", 8'(state), 8'd1);
        ticks(59);
        check("reserve_59_state", 8'(state), 8'd1);
        ticks(1);
        check("reserve_60_state", 8'(state), 8'd2);

        // Right miss, then a simultaneous miss replay with serve_dir=1.
        miss(1'b0, 1'b1);
        check("mr_sl", 8'(score_left), 8'd1);
        check("mr_dir", 8'(serve_dir), 8'd1);
        check("mr_state", 8'(state), 8'd3);
        ticks(90);
        check("mr_back_play", 8'(state), 8'd2);
        miss(1'b1, 1'b1);
        check("both_sl", 8'(score_left), 8'd1);
        check("both_sr", 8'(score_right), 8'd1);
        check("both_dir", 8'(serve_dir), 8'd0);
        check("both_state", 8'(state), 8'd3);
        ticks(90);

        // Left player runs to seven.
        for (int i = 0; i < 5; i++) begin
            miss(1'b0, 1'b1);
            ticks(90);
        end
        check("six_state", 8'(state), 8'd2);
        check("six_sl", 8'(score_left), 8'd6);
        miss(1'b0, 1'b1);
        check("seven_sl", 8'(score_left), 8'd7);
        check("seven_state", 8'(state), 8'd3);
        check("seven_win_pending", 8'(winner), 8'd0);
        ticks(29);
        check("seven_29_state", 8'(state), 8'd3);
        ticks(1);
        check("over_state", 8'(state), 8'd4);
        check("over_winner", 8'(winner), 8'd1);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        ticks(5);
        check("over_frozen_state", 8'(state), 8'd4);
        check("over_frozen_sl", 8'(score_left), 8'd7);
        check("over_frozen_sr", 8'(score_right), 8'd1);
        check("over_frozen_win", 8'(winner), 8'd1);
        check("over_hold", 8'(ball_hold), 8'd1);
        start = 1'b1;
        cyc();
        check("restart_state", 8'(state), 8'd1);
        check("restart_sl", 8'(score_left), 8'd0);
        check("restart_sr", 8'(score_right), 8'd0);
        check("restart_win", 8'(winner), 8'd0);
        start = 1'b0;
        cyc();

        // Build a 3:2 score, then reset in the middle of PLAY with start held high.
        ticks(60);
        for (int i = 0; i < 3; i++) begin
            miss(1'b0, 1'b1);
            ticks(90);
        end
        for (int i = 0; i < 2; i++) begin
            miss(1'b1, 1'b0);
            ticks(90);
        end
        check("pre_rst_state", 8'(state), 8'd2);
        check("pre_rst_sl", 8'(score_left), 8'd3);
        check("pre_rst_sr", 8'(score_right), 8'd2);
        start = 1'b1;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_state", 8'(state), 8'd0);
        check("async_rst_sl", 8'(score_left), 8'd0);
        check("async_rst_sr", 8'(score_right), 8'd0);
        check("async_rst_play", 8'(play_en), 8'd0);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        cyc();
        check("held_start_idle", 8'(state), 8'd0);
        start = 1'b0;
        cyc();
        check("start_low_idle", 8'(state), 8'd0);
        start = 1'b1;
        cyc();
        check("new_edge_serve", 8'(state), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
